fifo_ring: RTL
==============

// Module: fifo_ring
// PURPOSE
//  Next-generation single-clock FWFT FIFO. Supports any DEPTH (non power of two), with explicit pointer wrap.
//  Runtime modes: NORMAL, CIRCULAR (replay stored contents) and OVERWRITE (drop oldest when full).
//  Full-range fill level, registered status flags and sticky overflow/underflow error flags.
//  Sits between producers/consumers in the streaming datapath as the general replacement FIFO.
// PARAMETERS
//  WIDTH     32  data word width in bits
//  DEPTH     5   storage entries, any integer >= 2
//  AE_LEVEL  1   almost_empty asserted when fill <= AE_LEVEL
//  AF_LEVEL  1   almost_full asserted when fill >= DEPTH-AF_LEVEL
// PORTS
//  clk          in   1                 clock, all logic on rising edge
//  reset        in   1                 synchronous, active-high; clears all state
//  mode         in   2                 0 NORMAL, 1 CIRCULAR, 2 OVERWRITE, 3 treated as NORMAL
//  flush        in   1                 synchronous clear of pointers/fill; error flags kept
//  err_clear    in   1                 clears overflow/underflow
//  datain       in   WIDTH             write data
//  write        in   1                 write request
//  read         in   1                 read (pop/advance) request
//  dataout      out  WIDTH             head word, registered, valid when valid=1
//  valid        out  1                 dataout holds a stored word (== !empty)
//  empty        out  1                 fill == 0
//  full         out  1                 fill == DEPTH
//  almost_empty out  1                 fill <= AE_LEVEL
//  almost_full  out  1                 fill >= DEPTH-AF_LEVEL
//  fill_level   out  $clog2(DEPTH+1)   entries stored, 0..DEPTH inclusive
//  dropped      out  1                 1-cycle pulse: oldest word discarded (OVERWRITE)
//  overflow     out  1                 sticky: write rejected
//  underflow    out  1                 sticky: read while empty
// BEHAVIOUR
//  Reset: pointers, fill=0; dataout=0, valid=0, empty=1, full=0, almost_empty=1 (AE_LEVEL>=0),
//   almost_full=(0>=DEPTH-AF_LEVEL), dropped=0, overflow=0, underflow=0. Reset wins over all inputs;
//   reset mid-burst discards content, with no partial write.
//  Pointers wr_ptr, beg_ptr, cur_ptr in 0..DEPTH-1; increment wraps DEPTH-1 -> 0 by compare, never by truncation.
//  rd_ok = read && fill!=0. underflow set when read && fill==0 (incl. same-cycle write into empty FIFO).
//  NORMAL: wr_ok = write && (fill!=DEPTH || rd_ok). A read pops: beg_ptr, cur_ptr advance; fill-1.
//   A write stores at wr_ptr, wr_ptr+1, fill+1. A read and write together leave fill unchanged (also when full).
//  CIRCULAR: a read advances only cur_ptr; when next cur_ptr == wr_ptr, cur_ptr <= beg_ptr (replay loop).
//   Fill never decreases. wr_ok = write && fill!=DEPTH; the read frees nothing.
//  OVERWRITE: as NORMAL, but write && full && !rd_ok stores the word, advances beg_ptr and cur_ptr, fill stays DEPTH,
//   and asserts dropped for 1 cycle.
//  overflow set when write && !wr_ok && mode!=OVERWRITE. err_clear clears both flags; a set in the same cycle wins.
//  Whenever mode!=CIRCULAR, next cur_ptr = next beg_ptr (leaving CIRCULAR resyncs to oldest word).
//  flush: fill=0, all pointers=0, valid=0, dataout=0 next edge; same-cycle write/read ignored; no error set.
//  Flags and fill_level are registered from next-state fill: a change is visible the edge after the request.
//  dataout is registered FWFT. It holds the word at next cur_ptr.
//   When next fill becomes 1 from 0, dataout takes datain directly (bypass).
//   Latency write->valid/dataout = 1 cycle. After a read, the next word appears on the same edge.
//  Memory is not reset; the read mux never selects an unwritten location while valid=1.
// TESTING
//  DEPTH=5 NORMAL: write 1..5 -> full=1, fill_level=5. 6th write -> overflow=1, data 1..5 intact. Read 5 -> 1,2,3,4,5, empty=1.
//  Wrap: 3 writes, 3 reads, repeated 4x (pointers cross 4->0) -> order preserved, fill_level never >3.
//  Write 0xA into empty with read same cycle -> underflow=1; next cycle valid=1, dataout=0xA, fill_level=1.
//  CIRCULAR, store 7,8,9: 7 reads -> 7,8,9,7,8,9,7 and fill_level stays 3. Switch to NORMAL, read -> 7.
//  OVERWRITE full with 1..5, write 6 -> dropped pulse, fill=5, reads give 2,3,4,5,6.
//  Full with 1..5 in NORMAL, read+write 0xB -> fill 5, then 2..5,0xB. Reset mid-burst -> reset values next edge.

Source files
------------

// File: rtl/fifo_ring.sv
// ============================================================================
// Module   : fifo_ring
// Brief    : Single-clock FWFT ring FIFO, any DEPTH, NORMAL/CIRCULAR/OVERWRITE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ring #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 5,
    parameter int AE_LEVEL = 1,
    parameter int AF_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic                       flush,
    input  logic                       err_clear,
    input  logic [WIDTH-1:0]           datain,
    input  logic                       write,
    input  logic                       read,
    output logic [WIDTH-1:0]           dataout,
    output logic                       valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       dropped,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int                c_FW       = $clog2(DEPTH + 1);
    localparam int                c_PW       = $clog2(DEPTH);
    localparam logic [c_PW-1:0]   c_LAST     = c_PW'(DEPTH - 1);
    localparam logic [c_FW-1:0]   c_DEPTH    = c_FW'(DEPTH);
    localparam logic [c_FW-1:0]   c_AE_THR   = c_FW'(AE_LEVEL);
    localparam logic [c_FW-1:0]   c_AF_THR   = c_FW'(DEPTH - AF_LEVEL);
    localparam logic [1:0]        c_MODE_CIRC = 2'd1;
    localparam logic [1:0]        c_MODE_OVW  = 2'd2;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_beg_ptr;
    logic [c_PW-1:0]  r_cur_ptr;
    logic [c_FW-1:0]  r_fill;
    logic [WIDTH-1:0] r_dataout;
    logic             r_valid;
    logic             r_empty;
    logic             r_full;
    logic             r_almost_empty;
    logic             r_almost_full;
    logic             r_dropped;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_circ;
    logic             w_ovw;
    logic             w_is_full;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_drop;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic [c_PW-1:0]  w_wr_next;
    logic [c_PW-1:0]  w_beg_next;
    logic [c_PW-1:0]  w_cur_next;
    logic [c_PW-1:0]  w_cur_inc;
    logic [c_FW-1:0]  w_fill_next;
    logic [WIDTH-1:0] w_dout_next;

    // Wrap by explicit compare so non power-of-two depths stay in range.
    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PW'(1);
    endfunction

    always_comb begin
        w_circ      = (mode == c_MODE_CIRC);
        w_ovw       = (mode == c_MODE_OVW);
        w_is_full   = (r_fill == c_DEPTH);
        w_rd_ok     = read && (r_fill != '0) && !flush;
        w_drop      = 1'b0;
        w_wr_ok     = 1'b0;
        w_ovf_set   = 1'b0;
        w_udf_set   = 1'b0;
        w_wr_next   = r_wr_ptr;
        w_beg_next  = r_beg_ptr;
        w_cur_next  = r_cur_ptr;
        w_cur_inc   = f_inc(r_cur_ptr);
        w_fill_next = r_fill;
        w_dout_next = '0;

        if (flush) begin
            w_wr_next   = '0;
            w_beg_next  = '0;
            w_cur_next  = '0;
            w_fill_next = '0;
        end else begin
            w_udf_set = read && (r_fill == '0);
            if (w_circ) begin
                w_wr_ok = write && !w_is_full;
                if (w_rd_ok)
                    w_cur_next = (w_cur_inc == r_wr_ptr) ? r_beg_ptr : w_cur_inc;
                if (w_wr_ok)
                    w_fill_next = r_fill + c_FW'(1);
            end else begin
                w_wr_ok = write && (!w_is_full || w_rd_ok || w_ovw);
                w_drop  = w_ovw && write && w_is_full && !w_rd_ok;
                if (w_rd_ok || w_drop)
                    w_beg_next = f_inc(r_beg_ptr);
                // Outside CIRCULAR the read cursor always tracks the oldest word.
                w_cur_next = w_beg_next;
                if (w_wr_ok && !w_rd_ok && !w_drop)
                    w_fill_next = r_fill + c_FW'(1);
                else if (!w_wr_ok && w_rd_ok)
                    w_fill_next = r_fill - c_FW'(1);
            end
            w_ovf_set = write && !w_wr_ok && !w_ovw;
            if (w_wr_ok)
                w_wr_next = f_inc(r_wr_ptr);
        end

        // Head slot being written this cycle is forwarded straight from datain.
        if (w_fill_next != '0) begin
            if (w_wr_ok && (r_wr_ptr == w_cur_next))
                w_dout_next = datain;
            else
                w_dout_next = r_mem[w_cur_next];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok && !reset)
            r_mem[r_wr_ptr] <= datain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_beg_ptr      <= '0;
            r_cur_ptr      <= '0;
            r_fill         <= '0;
            r_dataout      <= '0;
            r_valid        <= 1'b0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= (c_AF_THR == '0);
            r_dropped      <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_next;
            r_beg_ptr      <= w_beg_next;
            r_cur_ptr      <= w_cur_next;
            r_fill         <= w_fill_next;
            r_dataout      <= w_dout_next;
            r_valid        <= (w_fill_next != '0);
            r_empty        <= (w_fill_next == '0);
            r_full         <= (w_fill_next == c_DEPTH);
            r_almost_empty <= (w_fill_next <= c_AE_THR);
            r_almost_full  <= (w_fill_next >= c_AF_THR);
            r_dropped      <= w_drop;
            r_overflow     <= w_ovf_set ? 1'b1 : (err_clear ? 1'b0 : r_overflow);
            r_underflow    <= w_udf_set ? 1'b1 : (err_clear ? 1'b0 : r_underflow);
        end
    end

    assign dataout      = r_dataout;
    assign valid        = r_valid;
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign fill_level   = r_fill;
    assign dropped      = r_dropped;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

`default_nettype wire
